// File: rtl/ni_param.sv
// ============================================================================
//  Module   : ni_param (+ ni_param_fifo)
//  Purpose  : GPU <-> Dragonfly+ leaf-router network interface with header
//             translation, buffered valid/ready FIFOs and error counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ni_param_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ready_o
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q;
    logic [c_PTR_W-1:0] r_rd_ptr_q;
    logic [c_CNT_W-1:0] r_count_q;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_empty = (r_count_q == '0);
    assign valid_o = !w_empty;
    assign ready_o = (r_count_q != c_FULL);
    assign w_push  = push_i & ready_o;
    assign w_pop   = valid_o & pop_ready_i;
    assign rdata_o = w_empty ? '0 : r_mem_q[r_rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            if (w_push) r_wr_ptr_q <= r_wr_ptr_q + 1'b1;
            if (w_pop)  r_rd_ptr_q <= r_rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count_q <= r_count_q + 1'b1;
                2'b01:   r_count_q <= r_count_q - 1'b1;
                default: r_count_q <= r_count_q;
            endcase
        end
    end

    // Storage is not reset; an empty FIFO masks its output to zero instead.
    always_ff @(posedge clk) begin
        if (w_push) r_mem_q[r_wr_ptr_q] <= wdata_i;
    end
endmodule

module ni_param #(
    parameter int GPU_ID      = 1,
    parameter int DATA_W      = 16,
    parameter int GROUP_W     = 4,
    parameter int LEAF_W      = 2,
    parameter int ADDR_OFFSET = 3,
    parameter int MAX_GPU     = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] gpu_data_in,
    input  logic              gpu_valid_in,
    output logic              gpu_ready_out,
    output logic [DATA_W-1:0] gpu_data_out,
    output logic              gpu_valid_out,
    input  logic              gpu_ready_in,
    output logic [DATA_W-1:0] router_data_out,
    output logic              router_valid_out,
    input  logic              router_ready_in,
    input  logic [DATA_W-1:0] router_data_in,
    input  logic              router_valid_in,
    output logic              router_ready_out,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  inval_cnt
);
    localparam int c_HDR_W = GROUP_W + LEAF_W;
    localparam int c_PAY_W = DATA_W - c_HDR_W;
    localparam logic [c_HDR_W-1:0] c_OFFSET = c_HDR_W'(ADDR_OFFSET);
    localparam logic [c_HDR_W-1:0] c_MAX    = c_HDR_W'(MAX_GPU);
    localparam logic [c_HDR_W-1:0] c_MY_HDR = c_HDR_W'(GPU_ID + ADDR_OFFSET);

    logic [c_HDR_W-1:0] w_eg_dest;
    logic               w_eg_ok;
    logic               w_eg_fire;
    logic               w_g2r_push;
    logic [DATA_W-1:0]  w_g2r_wdata;
    logic [c_HDR_W-1:0] w_ig_hdr;
    logic               w_ig_ok;
    logic               w_ig_fire;
    logic               w_r2g_push;
    logic [DATA_W-1:0]  w_r2g_wdata;
    logic [CNT_W-1:0]   r_inval_cnt_q;
    logic [CNT_W-1:0]   w_inval_cnt_d;
    logic [CNT_W-1:0]   r_drop_cnt_q;
    logic [CNT_W-1:0]   w_drop_cnt_d;

    // Egress: GPU ID -> routing header
    assign w_eg_dest   = gpu_data_in[DATA_W-1 -: c_HDR_W];
    assign w_eg_ok     = (w_eg_dest != '0) && (w_eg_dest <= c_MAX);
    assign w_eg_fire   = gpu_valid_in & gpu_ready_out;
    assign w_g2r_push  = w_eg_fire & w_eg_ok;
    assign w_g2r_wdata = {w_eg_dest + c_OFFSET, gpu_data_in[c_PAY_W-1:0]};

    // Ingress: only flits addressed to this endpoint are kept
    assign w_ig_hdr    = router_data_in[DATA_W-1 -: c_HDR_W];
    assign w_ig_ok     = (w_ig_hdr == c_MY_HDR);
    assign w_ig_fire   = router_valid_in & router_ready_out;
    assign w_r2g_push  = w_ig_fire & w_ig_ok;
    assign w_r2g_wdata = {w_ig_hdr - c_OFFSET, router_data_in[c_PAY_W-1:0]};

    ni_param_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_g2r (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_g2r_push),
        .wdata_i     (w_g2r_wdata),
        .pop_ready_i (router_ready_in),
        .valid_o     (router_valid_out),
        .rdata_o     (router_data_out),
        .ready_o     (gpu_ready_out)
    );

    ni_param_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_r2g (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_r2g_push),
        .wdata_i     (w_r2g_wdata),
        .pop_ready_i (gpu_ready_in),
        .valid_o     (gpu_valid_out),
        .rdata_o     (gpu_data_out),
        .ready_o     (router_ready_out)
    );

    // Saturating error counters; clear has priority over a coincident increment
    always_comb begin
        w_inval_cnt_d = r_inval_cnt_q;
        w_drop_cnt_d  = r_drop_cnt_q;
        if (cnt_clr) begin
            w_inval_cnt_d = '0;
            w_drop_cnt_d  = '0;
        end else begin
            if (w_eg_fire && !w_eg_ok && (r_inval_cnt_q != '1))
                w_inval_cnt_d = r_inval_cnt_q + 1'b1;
            if (w_ig_fire && !w_ig_ok && (r_drop_cnt_q != '1))
                w_drop_cnt_d = r_drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inval_cnt_q <= '0;
            r_drop_cnt_q  <= '0;
        end else begin
            r_inval_cnt_q <= w_inval_cnt_d;
            r_drop_cnt_q  <= w_drop_cnt_d;
        end
    end

    assign inval_cnt = r_inval_cnt_q;
    assign drop_cnt  = r_drop_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_ni_param.sv
// ============================================================================
//  Module   : tb_ni_param
//  Purpose  : Directed, table-driven self-checking bench for ni_param.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ni_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpu_data_in;
    logic        gpu_valid_in;
    logic        gpu_ready_out;
    logic [15:0] gpu_data_out;
    logic        gpu_valid_out;
    logic        gpu_ready_in;
    logic [15:0] router_data_out;
    logic        router_valid_out;
    logic        router_ready_in;
    logic [15:0] router_data_in;
    logic        router_valid_in;
    logic        router_ready_out;
    logic        cnt_clr;
    logic [7:0]  drop_cnt;
    logic [7:0]  inval_cnt;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        egress;
        logic [15:0] din;
        logic        exp_v;
        logic [15:0] exp_d;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] q[$];

    always #5 clk = ~clk;

    ni_param dut (
        .clk              (clk),
        .reset            (reset),
        .gpu_data_in      (gpu_data_in),
        .gpu_valid_in     (gpu_valid_in),
        .gpu_ready_out    (gpu_ready_out),
        .gpu_data_out     (gpu_data_out),
        .gpu_valid_out    (gpu_valid_out),
        .gpu_ready_in     (gpu_ready_in),
        .router_data_out  (router_data_out),
        .router_valid_out (router_valid_out),
        .router_ready_in  (router_ready_in),
        .router_data_in   (router_data_in),
        .router_valid_in  (router_valid_in),
        .router_ready_out (router_ready_out),
        .cnt_clr          (cnt_clr),
        .drop_cnt         (drop_cnt),
        .inval_cnt        (inval_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Flit with raw 6-bit header field d and 10-bit payload p
    function automatic logic [15:0] mk(input int d, input logic [9:0] p);
        mk = {6'(d), p};
    endfunction

    // Expected router-side flit for destination GPU d
    function automatic logic [15:0] eg(input int d, input logic [9:0] p);
        eg = {6'(d + 3), p};
    endfunction

    initial begin
        vecs[0] = '{1'b1, 16'h0C05, 1'b1, 16'h1805};  // dest 3
        vecs[1] = '{1'b1, 16'h17FF, 1'b1, 16'h23FF};  // dest 5
        vecs[2] = '{1'b1, 16'h8000, 1'b1, 16'h8C00};  // dest 32 (max)
        vecs[3] = '{1'b1, 16'h0001, 1'b0, 16'h0000};  // dest 0 invalid
        vecs[4] = '{1'b1, 16'h8412, 1'b0, 16'h0000};  // dest 33 invalid
        vecs[5] = '{1'b0, 16'h12AA, 1'b1, 16'h06AA};  // hdr 000100 ours
        vecs[6] = '{1'b0, 16'h16AA, 1'b0, 16'h0000};  // hdr 000101 misdirected
        vecs[7] = '{1'b0, 16'h1000, 1'b1, 16'h0400};  // ours, zero payload

        reset = 1'b1; cnt_clr = 1'b0;
        gpu_valid_in = 1'b0; gpu_data_in = '0; gpu_ready_in = 1'b1;
        router_valid_in = 1'b0; router_data_in = '0; router_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_gpu_ready", 32'(gpu_ready_out), 32'd1);
        chk("rst_rtr_ready", 32'(router_ready_out), 32'd1);
        chk("rst_rtr_valid", 32'(router_valid_out), 32'd0);
        chk("rst_gpu_valid", 32'(gpu_valid_out), 32'd0);
        chk("rst_rtr_data", 32'(router_data_out), 32'd0);
        chk("rst_gpu_data", 32'(gpu_data_out), 32'd0);
        chk("rst_cnts", {16'd0, drop_cnt, inval_cnt}, 32'd0);

        // Single-flit vectors, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vecs[i].egress) begin
                gpu_valid_in = 1'b1; gpu_data_in = vecs[i].din;
            end else begin
                router_valid_in = 1'b1; router_data_in = vecs[i].din;
            end
            @(negedge clk);
            gpu_valid_in = 1'b0; router_valid_in = 1'b0;
            if (vecs[i].egress) begin
                chk($sformatf("vec%0d_valid", i), 32'(router_valid_out), 32'(vecs[i].exp_v));
                chk($sformatf("vec%0d_data", i), 32'(router_data_out), 32'(vecs[i].exp_d));
            end else begin
                chk($sformatf("vec%0d_valid", i), 32'(gpu_valid_out), 32'(vecs[i].exp_v));
                chk($sformatf("vec%0d_data", i), 32'(gpu_data_out), 32'(vecs[i].exp_d));
            end
        end
        chk("inval_cnt_2", 32'(inval_cnt), 32'd2);
        chk("drop_cnt_1", 32'(drop_cnt), 32'd1);

        // Clear coinciding with an invalid flit
        @(negedge clk);
        cnt_clr = 1'b1; gpu_valid_in = 1'b1; gpu_data_in = 16'h0001;
        @(negedge clk);
        cnt_clr = 1'b0; gpu_valid_in = 1'b0;
        chk("clr_inval", 32'(inval_cnt), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_no_valid", 32'(router_valid_out), 32'd0);

        // Saturation: 260 invalid flits back to back
        gpu_valid_in = 1'b1; gpu_data_in = 16'h8400;
        repeat (260) @(negedge clk);
        gpu_valid_in = 1'b0;
        chk("inval_sat", 32'(inval_cnt), 32'd255);
        chk("sat_no_valid", 32'(router_valid_out), 32'd0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_after_sat", 32'(inval_cnt), 32'd0);

        // Backpressure: fill egress FIFO, then drain in order
        router_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("fill%0d_ready", i), 32'(gpu_ready_out), 32'd1);
            gpu_valid_in = 1'b1; gpu_data_in = mk(i + 1, 10'(256 + i));
        end
        @(negedge clk);
        gpu_data_in = mk(9, 10'h3FF);   // offered while full, must be refused
        chk("full_ready_low", 32'(gpu_ready_out), 32'd0);
        chk("full_head", 32'(router_data_out), 32'(eg(1, 10'd256)));
        @(negedge clk);
        chk("full_hold_valid", 32'(router_valid_out), 32'd1);
        chk("full_hold_data", 32'(router_data_out), 32'(eg(1, 10'd256)));
        gpu_valid_in = 1'b0; router_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(router_valid_out), 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(router_data_out), 32'(eg(i + 1, 10'(256 + i))));
            @(negedge clk);
        end
        chk("drain_empty", 32'(router_valid_out), 32'd0);
        chk("drain_data0", 32'(router_data_out), 32'd0);

        // Seven entries with simultaneous push and pop for 20 cycles
        router_ready_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            gpu_valid_in = 1'b1; gpu_data_in = mk(i + 1, 10'(i * 5));
            q.push_back(eg(i + 1, 10'(i * 5)));
            @(negedge clk);
        end
        router_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("pp%0d_ready", i), 32'(gpu_ready_out), 32'd1);
            chk($sformatf("pp%0d_data", i), 32'(router_data_out), 32'(q[0]));
            void'(q.pop_front());
            gpu_data_in = mk((i % 32) + 1, 10'(i * 37 + 11));
            q.push_back(eg((i % 32) + 1, 10'(i * 37 + 11)));
            @(negedge clk);
        end
        gpu_valid_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("pp_drain%0d", i), 32'(router_data_out), 32'(q[0]));
            void'(q.pop_front());
            @(negedge clk);
        end
        chk("pp_empty", 32'(router_valid_out), 32'd0);

        // Reset mid-operation with both FIFOs holding flits
        gpu_ready_in = 1'b0; router_ready_in = 1'b0;
        router_valid_in = 1'b1; router_data_in = 16'h16AA;
        gpu_valid_in = 1'b1; gpu_data_in = 16'h0001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            router_data_in = mk(4, 10'(i));
            gpu_valid_in = (i < 5);
            gpu_data_in = mk(2, 10'(i));
        end
        @(negedge clk);
        router_valid_in = 1'b0; gpu_valid_in = 1'b0;
        chk("pre_rst_rtr_ready", 32'(router_ready_out), 32'd0);
        chk("pre_rst_gpu_data", 32'(gpu_data_out), 32'h0400);
        chk("pre_rst_cnts", {16'd0, drop_cnt, inval_cnt}, 32'h0101);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valids", {30'd0, router_valid_out, gpu_valid_out}, 32'd0);
        chk("mid_rst_readies", {30'd0, router_ready_out, gpu_ready_out}, 32'd3);
        chk("mid_rst_cnts", {16'd0, drop_cnt, inval_cnt}, 32'd0);
        chk("mid_rst_data", {router_data_out, gpu_data_out}, 32'd0);
        gpu_ready_in = 1'b1; router_ready_in = 1'b1;
        @(negedge clk);
        chk("post_rst_valids", {30'd0, router_valid_out, gpu_valid_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ni_param.md
# ni_param

Parametrised second-generation GPU network interface for the Dragonfly+ NoC. It sits between one GPU endpoint and its leaf router and translates destination GPU IDs into {group, leaf} routing headers on egress. On ingress it filters and translates headers back to GPU IDs. Both directions use buffered full valid/ready handshakes with correct full/empty tracking and ingress backpressure toward the router. Saturating counters record misdirected and invalid-destination flits.

## Interface
- GPU_ID, 1: this endpoint's GPU ID (1..MAX_GPU).
- DATA_W, 16: flit width; header occupies bits [DATA_W-1 -: HDR_W].
- GROUP_W, 4: group field width (header MSBs).
- LEAF_W, 2: leaf field width (header LSBs); HDR_W = GROUP_W+LEAF_W, HDR_W < DATA_W.
- ADDR_OFFSET, 3: header = dest_id + ADDR_OFFSET (ID 1 -> 6'b000100).
- MAX_GPU, 32: highest legal GPU ID; MAX_GPU+ADDR_OFFSET <= 2^HDR_W-1.
- FIFO_DEPTH, 8: entries per direction; power of two, >= 2.
- CNT_W, 8: width of the error counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- gpu_data_in  in  DATA_W  egress flit; top HDR_W bits = destination GPU ID.
- gpu_valid_in  in  1  egress flit valid.
- gpu_ready_out  out  1  egress FIFO can accept.
- gpu_data_out  out  DATA_W  ingress flit to GPU, header = source-side GPU ID (= GPU_ID).
- gpu_valid_out  out  1  ingress flit valid.
- gpu_ready_in  in  1  GPU accepts ingress flit.
- router_data_out  out  DATA_W  egress flit with routing header.
- router_valid_out  out  1  egress flit valid.
- router_ready_in  in  1  router accepts egress flit.
- router_data_in  in  DATA_W  ingress flit with routing header.
- router_valid_in  in  1  ingress flit valid.
- router_ready_out  out  1  ingress FIFO can accept.
- cnt_clr  in  1  synchronous clear of both counters.
- drop_cnt  out  CNT_W  misdirected ingress flits discarded.
- inval_cnt  out  CNT_W  invalid-destination egress flits discarded.

## Operation
- Two independent FIFOs (g2r, r2g), each FIFO_DEPTH entries, pointers log2(FIFO_DEPTH) bits wrapping mod DEPTH, count width log2(FIFO_DEPTH)+1.
- gpu_ready_out = (g2r count != FIFO_DEPTH); router_ready_out = (r2g count != FIFO_DEPTH). No full-cycle lookahead: when full, ready is low even if a pop occurs the same cycle.
- Egress transfer on gpu_valid_in & gpu_ready_out. dest_id = header field. If 1 <= dest_id <= MAX_GPU: push {dest_id+ADDR_OFFSET (HDR_W bits), payload}. Otherwise the flit is consumed, not pushed, and inval_cnt increments.
- Ingress transfer on router_valid_in & router_ready_out. If header == GPU_ID+ADDR_OFFSET: push {header-ADDR_OFFSET, payload}. Otherwise the flit is consumed, not pushed, and drop_cnt increments.
- FIFO head drives the output: valid_out = !empty. data_out = head entry when valid, all-zero when empty. Pop on valid_out & ready_in.
- valid_out and data_out stay stable while ready_in is low (no retraction, no reorder).
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance. Legal when not full, including DEPTH-1 entries and the one-entry case.
- Counters saturate at 2^CNT_W-1. When cnt_clr and an increment coincide, clear wins and the result is 0.

## Timing
- Reset values: all counts, pointers and counters 0; valid outputs 0; data outputs 0. gpu_ready_out and router_ready_out are 1 in the first cycle after reset.
- Reset asserted mid-operation flushes both FIFOs at that edge; flits in flight are lost.
- Latency: a flit accepted at edge k is presented with valid high in the cycle after edge k (1 cycle), if the FIFO was empty.
- Throughput: 1 flit/cycle per direction, sustained when the downstream ready is held high.
- A discarded flit, whether invalid or misdirected, produces its counter update at the accepting edge. It never causes valid_out.

## Test plan
- Reset, then GPU_ID=1; send gpu_data_in=16'h0C05 (dest 3). Required: router_data_out=16'h1805 (header 6'b000110) one cycle later; GPU_ID=1 stays unchanged.
- router_ready_in=0 with 8 back-to-back valid egress flits. Required: gpu_ready_out falls after the 8th; router_data_out holds the first flit. Then router_ready_in=1. Required: 8 flits exit in order, one per cycle.
- Ingress header 6'b000100 with payload 10'h2AA. Required: gpu_data_out=16'h06AA. Ingress header 6'b000101. Required: no gpu_valid_out and drop_cnt=1.
- Egress dest 0 and dest 33. Required: nothing reaches router_valid_out and inval_cnt=2. Hold cnt_clr with a coincident invalid flit. Required: inval_cnt=0.
- FIFO at 7 entries with simultaneous push and pop for 20 cycles, wrapping pointers. Required: count stays 7 and data order is preserved.
- Assert reset with 5 flits queued. Required: valid outputs 0 next cycle, ready outputs 1, and the counters read 0.
